gpio_port_bank: RTL and testbench
=================================

// Module: gpio_port_bank
// PURPOSE
//  Parametrised memory-mapped GPIO port. Successor to the fixed 8-bit port_a/RGB output latches on the SoC.
//  Adds per-pin direction, atomic set/clear/toggle, synchronised inputs and edge-detect interrupts.
//  Sits on the SoC I/O bus; one instance per physical port (PMOD A, PMOD B, RGB LED).
// PARAMETERS
//  WIDTH        8    pins in this port (1..32)
//  SYNC_STAGES  2    input synchroniser flops (>=2)
//  RESET_OUT    '0   pin_out value after reset
//  RESET_DIR    '1   pin_oe value after reset (1 = output)
// PORTS
//  clk_48mhz  in   1      system clock
//  reset      in   1      asynchronous, active-high reset
//  addr       in   4      word register index
//  wr_en      in   1      write strobe, one cycle
//  rd_en      in   1      read strobe, one cycle
//  wr_data    in   32     write data; bits above WIDTH ignored
//  rd_data    out  32     read data; bits above WIDTH read 0
//  rd_valid   out  1      rd_data valid, one cycle after rd_en
//  pin_in     in   WIDTH  raw asynchronous pad inputs
//  pin_out    out  WIDTH  output register
//  pin_oe     out  WIDTH  direction, 1 = drive
//  irq        out  1      registered OR of (status & mask)
// BEHAVIOUR
//  Register map (addr):
//   0 OUT    rw
//   1 SET    w; OUT |= d
//   2 CLR    w; OUT &= ~d
//   3 TGL    w; OUT ^= d
//   4 DIR    rw
//   5 IN     ro; synchronised pins
//   6 RISE   rw; rising-edge enable
//   7 FALL   rw; falling-edge enable
//   8 STAT   rw1c
//   9 MASK   rw
//  - Reads of write-only regs return 0. addr 10..15: writes ignored, reads return 0.
//  - Reset (async assert, sync-free deassert is caller's job) sets: OUT=RESET_OUT, DIR=RESET_DIR, RISE/FALL/STAT/MASK=0,
//    sync chain=0, rd_data=0, rd_valid=0, irq=0.
//  - Write takes effect on pin_out/pin_oe the cycle after wr_en. Read: rd_data/rd_valid registered, latency 1.
//  - wr_en and rd_en in the same cycle: both honoured. A read returns the pre-write value.
//  - Inputs: pin_in passes SYNC_STAGES flops, then one more flop (prev). IN reads the last sync stage.
//    rise[i] = sync & ~prev & RISE[i]; fall[i] = ~sync & prev & FALL[i]. Edge detection is active regardless of DIR.
//  - STAT[i] sets on an enabled edge and stays set until a 1 is written to bit i.
//    If a new edge and a W1C on the same bit occur in one cycle, the edge wins and the bit stays 1.
//  - irq = |(STAT & MASK), registered, so irq asserts one cycle after STAT sets.
//  - Pin-to-STAT latency: SYNC_STAGES+1 cycles. Pin pulses shorter than 1 clock may be missed; this is not an error.
//  - Unused wr_data bits [31:WIDTH] are dropped with no error.
// STRUCTURE
//  - gpio_pkg: register index constants (GPIO_OUT..GPIO_MASK) and the typedef gpio_addr_t.
//  - Sub-module gpio_sync_edge (WIDTH, SYNC_STAGES): synchroniser plus prev flop.
//    It outputs sync_q, rise_q and fall_q. It is the only block touching pin_in.
//  - Top level contains the register file, the read mux and the irq flop.
// TESTING
//  1 Reset: hold reset mid-stream -> pin_out=0x00, pin_oe=0xFF, irq=0, rd_valid=0 immediately (async).
//  2 Atomic ops: OUT<=0xA5; SET 0x0F; CLR 0x81; TGL 0xFF -> pin_out 0xA5,0xAF,0x2E,0xD1 on successive cycles.
//  3 Read: rd_en addr 5 with pin_in=0x3C held >=3 cycles -> rd_valid next cycle, rd_data=0x0000003C.
//  4 Edge IRQ: RISE=0x01, MASK=0x01; pin_in[0] 0->1 -> STAT=0x01 after 3 cycles, irq one cycle later.
//    W1C 0x01 -> irq drops.
//  5 Edge/W1C race: FALL=0x02; falling edge on pin 1 in the same cycle as W1C 0x02 -> STAT[1] stays 1.
//  6 Width: WIDTH=3; write 0xFFFFFFFF to OUT -> pin_out=3'b111, read OUT=0x00000007. Read addr 12 -> 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map for the memory-mapped GPIO port bank.
package gpio_pkg;

  typedef logic [3:0] gpio_addr_t;

  localparam int GPIO_BUS_W = 32;

  localparam gpio_addr_t GPIO_OUT  = 4'd0;
  localparam gpio_addr_t GPIO_SET  = 4'd1;
  localparam gpio_addr_t GPIO_CLR  = 4'd2;
  localparam gpio_addr_t GPIO_TGL  = 4'd3;
  localparam gpio_addr_t GPIO_DIR  = 4'd4;
  localparam gpio_addr_t GPIO_IN   = 4'd5;
  localparam gpio_addr_t GPIO_RISE = 4'd6;
  localparam gpio_addr_t GPIO_FALL = 4'd7;
  localparam gpio_addr_t GPIO_STAT = 4'd8;
  localparam gpio_addr_t GPIO_MASK = 4'd9;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with a trailing history flop; the only logic that sees raw pin_in.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise_q,
  output logic [WIDTH-1:0] fall_q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0]                  prev_reg;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      chain_reg <= '0;
      prev_reg  <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_in};
      prev_reg  <= chain_reg[SYNC_STAGES-1];
    end
  end

  assign sync_q = chain_reg[SYNC_STAGES-1];

  // Edges are decoded straight from flop outputs so STAT can capture them on the next clock.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign rise_q[gi] =  sync_q[gi] & ~prev_reg[gi];
      assign fall_q[gi] = ~sync_q[gi] &  prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/gpio_port_bank.sv
// Memory-mapped GPIO port: output/direction registers, atomic bit ops, edge-detect interrupts.
module gpio_port_bank
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '1
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  gpio_addr_t            addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [GPIO_BUS_W-1:0] wr_data,
  output logic [GPIO_BUS_W-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [WIDTH-1:0]      pin_in,
  output logic [WIDTH-1:0]      pin_out,
  output logic [WIDTH-1:0]      pin_oe,
  output logic                  irq
);

  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] dir_reg, dir_next;
  logic [WIDTH-1:0] rise_en_reg, rise_en_next;
  logic [WIDTH-1:0] fall_en_reg, fall_en_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [WIDTH-1:0] stat_reg, stat_next;
  logic [WIDTH-1:0] sync_q, rise_q, fall_q;
  logic [WIDTH-1:0] wd, w1c, edge_hit;
  logic [GPIO_BUS_W-1:0] rd_mux, rd_data_reg;
  logic rd_valid_reg, irq_reg;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .pin_in    (pin_in),
    .sync_q    (sync_q),
    .rise_q    (rise_q),
    .fall_q    (fall_q)
  );

  assign wd = wr_data[WIDTH-1:0];

  generate
    if (WIDTH < GPIO_BUS_W) begin : g_drop_hi
      logic unused_wr_hi;
      assign unused_wr_hi = ^wr_data[GPIO_BUS_W-1:WIDTH];
    end
  endgenerate

  always_comb begin
    out_next     = out_reg;
    dir_next     = dir_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    mask_next    = mask_reg;
    if (wr_en) begin
      case (addr)
        GPIO_OUT:  out_next     = wd;
        GPIO_SET:  out_next     = out_reg | wd;
        GPIO_CLR:  out_next     = out_reg & ~wd;
        GPIO_TGL:  out_next     = out_reg ^ wd;
        GPIO_DIR:  dir_next     = wd;
        GPIO_RISE: rise_en_next = wd;
        GPIO_FALL: fall_en_next = wd;
        GPIO_MASK: mask_next    = wd;
        default:   ;
      endcase
    end
  end

  assign w1c = (wr_en && addr == GPIO_STAT) ? wd : '0;

  // A fresh edge overrides a simultaneous write-one-to-clear on the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stat
      assign edge_hit[gi]  = (rise_q[gi] & rise_en_reg[gi]) | (fall_q[gi] & fall_en_reg[gi]);
      assign stat_next[gi] = edge_hit[gi] | (stat_reg[gi] & ~w1c[gi]);
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (addr)
      GPIO_OUT:  rd_mux[WIDTH-1:0] = out_reg;
      GPIO_DIR:  rd_mux[WIDTH-1:0] = dir_reg;
      GPIO_IN:   rd_mux[WIDTH-1:0] = sync_q;
      GPIO_RISE: rd_mux[WIDTH-1:0] = rise_en_reg;
      GPIO_FALL: rd_mux[WIDTH-1:0] = fall_en_reg;
      GPIO_STAT: rd_mux[WIDTH-1:0] = stat_reg;
      GPIO_MASK: rd_mux[WIDTH-1:0] = mask_reg;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      out_reg      <= RESET_OUT;
      dir_reg      <= RESET_DIR;
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      mask_reg     <= '0;
      stat_reg     <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      out_reg      <= out_next;
      dir_reg      <= dir_next;
      rise_en_reg  <= rise_en_next;
      fall_en_reg  <= fall_en_next;
      mask_reg     <= mask_next;
      stat_reg     <= stat_next;
      rd_valid_reg <= rd_en;
      irq_reg      <= |(stat_reg & mask_reg);
      if (rd_en) begin
        rd_data_reg <= rd_mux;
      end
    end
  end

  assign pin_out  = out_reg;
  assign pin_oe   = dir_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed plus randomised bench for gpio_port_bank against a cycle-level reference model.
module tb_gpio_port_bank;

  localparam int SS = 2;
  localparam int PH = 4;

  logic        clk_48mhz = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        wr_en, rd_en;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, irq;
  logic [7:0]  pin_in, pin_out, pin_oe;

  logic [3:0]  addr3;
  logic        wr_en3, rd_en3;
  logic [31:0] wr_data3, rd_data3;
  logic        rd_valid3, irq3;
  logic [2:0]  pin_in3, pin_out3, pin_oe3;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: architectural registers plus a history of sampled pin values.
  logic [7:0]  m_out, m_dir, m_rise, m_fall, m_stat, m_mask;
  logic        m_irq, m_rd_valid;
  logic [31:0] m_rd_data;
  logic [7:0]  ph [PH];

  always #10 clk_48mhz = ~clk_48mhz;

  gpio_port_bank dut (
    .clk_48mhz (clk_48mhz), .reset (reset), .addr (addr), .wr_en (wr_en), .rd_en (rd_en),
    .wr_data (wr_data), .rd_data (rd_data), .rd_valid (rd_valid), .pin_in (pin_in),
    .pin_out (pin_out), .pin_oe (pin_oe), .irq (irq)
  );

  gpio_port_bank #(.WIDTH(3)) dut3 (
    .clk_48mhz (clk_48mhz), .reset (reset), .addr (addr3), .wr_en (wr_en3), .rd_en (rd_en3),
    .wr_data (wr_data3), .rd_data (rd_data3), .rd_valid (rd_valid3), .pin_in (pin_in3),
    .pin_out (pin_out3), .pin_oe (pin_oe3), .irq (irq3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_out = 8'h00; m_dir = 8'hFF; m_rise = '0; m_fall = '0; m_stat = '0; m_mask = '0;
    m_irq = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    for (int i = 0; i < PH; i++) ph[i] = '0;
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return m_out;
      4'd4: return m_dir;
      4'd5: return ph[SS-1];
      4'd6: return m_rise;
      4'd7: return m_fall;
      4'd8: return m_stat;
      4'd9: return m_mask;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: advance the model on the edge, then compare the DUT 1 ns later.
  task automatic step();
    logic [7:0] d, sync_v, prev_v, edges, w1c;
    @(posedge clk_48mhz);
    d      = wr_data[7:0];
    sync_v = ph[SS-1];
    prev_v = ph[SS];
    if (rd_en) m_rd_data = {24'h0, model_read(addr)};
    m_rd_valid = rd_en;
    m_irq  = |(m_stat & m_mask);
    edges  = (sync_v & ~prev_v & m_rise) | (~sync_v & prev_v & m_fall);
    w1c    = (wr_en && addr == 4'd8) ? d : 8'h00;
    m_stat = (m_stat & ~w1c) | edges;
    if (wr_en) begin
      case (addr)
        4'd0: m_out  = d;
        4'd1: m_out  = m_out | d;
        4'd2: m_out  = m_out & ~d;
        4'd3: m_out  = m_out ^ d;
        4'd4: m_dir  = d;
        4'd6: m_rise = d;
        4'd7: m_fall = d;
        4'd9: m_mask = d;
        default: ;
      endcase
    end
    for (int i = PH - 1; i > 0; i--) ph[i] = ph[i-1];
    ph[0] = pin_in;
    #1;
    chk("pin_out", pin_out, m_out);
    chk("pin_oe", pin_oe, m_dir);
    chk("irq", irq, m_irq);
    chk("rd_valid", rd_valid, m_rd_valid);
    if (m_rd_valid) chk("rd_data", rd_data, m_rd_data);
  endtask

  task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; addr = a; wr_data = d;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic bus3(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    wr_en3 = w; rd_en3 = r; addr3 = a; wr_data3 = d;
    @(posedge clk_48mhz);
    #1;
    wr_en3 = 1'b0; rd_en3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; pin_in = '0;
    addr3 = '0; wr_en3 = 1'b0; rd_en3 = 1'b0; wr_data3 = '0; pin_in3 = '0;
    model_reset();
    repeat (2) @(posedge clk_48mhz);
    #1;
    chk("rst_pin_out", pin_out, 32'h00);
    chk("rst_pin_oe", pin_oe, 32'hFF);
    chk("rst_irq", irq, 1'b0);
    reset = 1'b0;

    // Atomic set/clear/toggle sequence.
    bus(1, 0, 4'd0, 32'h0000_00A5); chk("out_write", pin_out, 32'hA5);
    bus(1, 0, 4'd1, 32'h0000_000F); chk("set", pin_out, 32'hAF);
    bus(1, 0, 4'd2, 32'h0000_0081); chk("clr", pin_out, 32'h2E);
    bus(1, 0, 4'd3, 32'h0000_00FF); chk("tgl", pin_out, 32'hD1);

    // Synchronised input read.
    pin_in = 8'h3C;
    repeat (3) step();
    bus(0, 1, 4'd5, 32'h0);
    chk("in_valid", rd_valid, 1'b1);
    chk("in_data", rd_data, 32'h0000_003C);

    // Rising-edge interrupt and its clear.
    bus(1, 0, 4'd6, 32'h01);
    bus(1, 0, 4'd9, 32'h01);
    pin_in = 8'h3D;
    repeat (3) step();
    chk("irq_not_yet", irq, 1'b0);
    bus(0, 1, 4'd8, 32'h0);
    chk("stat_rise", rd_data, 32'h01);
    chk("irq_set", irq, 1'b1);
    bus(1, 0, 4'd8, 32'h01);
    step();
    chk("irq_cleared", irq, 1'b0);

    // Falling edge colliding with W1C on the same bit.
    bus(1, 0, 4'd6, 32'h00);
    bus(1, 0, 4'd7, 32'h02);
    pin_in = 8'h3F; repeat (4) step();
    pin_in = 8'h3D; repeat (4) step();
    pin_in = 8'h3F; repeat (4) step();
    pin_in = 8'h3D; step(); step();
    bus(1, 0, 4'd8, 32'h02);
    bus(0, 1, 4'd8, 32'h0);
    chk("race_stat", rd_data, 32'h02);

    // Asynchronous reset mid-stream, with state away from reset values.
    bus(1, 0, 4'd9, 32'h02);
    bus(1, 0, 4'd4, 32'h0F);
    bus(0, 1, 4'd0, 32'h0);
    chk("pre_rst_irq", irq, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_pin_out", pin_out, 32'h00);
    chk("async_pin_oe", pin_oe, 32'hFF);
    chk("async_irq", irq, 1'b0);
    chk("async_rd_valid", rd_valid, 1'b0);
    chk("async_rd_data", rd_data, 32'h0);
    @(posedge clk_48mhz);
    #1;
    reset = 1'b0;
    model_reset();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      pin_in = 8'($urandom);
      bus(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), $urandom);
    end

    // Narrow instance: upper write bits dropped, unmapped address reads zero.
    bus3(1, 0, 4'd0, 32'hFFFF_FFFF);
    chk("w3_pin_out", pin_out3, 32'h7);
    bus3(0, 1, 4'd0, 32'h0);
    chk("w3_rd_valid", rd_valid3, 1'b1);
    chk("w3_rd_out", rd_data3, 32'h0000_0007);
    bus3(0, 1, 4'd12, 32'h0);
    chk("w3_rd_12", rd_data3, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
